bcd_to_bin_seq: RTL

- Sequential BCD-to-binary converter; the inverse of the binary-to-digit split path.
- Takes NDIG packed BCD digits, most significant digit (MSD) in the top nibble, and folds them MSD-first with acc = acc*10 + digit, one digit per clock.
- Uses a start/busy/done handshake and flags invalid digits.
- Feeds digit-entry / display-readback paths that need a plain binary value for arithmetic units such as the 8-bit subtractor.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_mac10.sv | 20 ++
 rtl/bcd_to_bin_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the BCD-to-binary conversion path.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  function automatic logic bcd_digit_valid(input logic [3:0] nibble);
    return nibble <= BCD_MAX_DIGIT;
  endfunction

  // Smallest width w with 2^w > 10^ndig - 1, i.e. enough bits for the largest decimal value.
  function automatic int min_bin_width(input int ndig);
    longint max_val;
    int w;
    max_val = 1;
    for (int i = 0; i < ndig; i++) max_val = max_val * 10;
    max_val = max_val - 1;
    w = 1;
    while ((longint'(1) << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// One fold step of the BCD-to-binary conversion: result = acc*10 + digit.
module bcd_mac10 #(
  parameter int OUT_W = 8
) (
  input  logic [OUT_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [OUT_W-1:0] result
);

  logic [OUT_W+3:0] acc_w;
  logic [OUT_W+3:0] wide;
  logic             unused_hi;

  // *10 built from shifts; the OUT_W sizing rule guarantees the top bits stay clear.
  assign acc_w     = {4'b0000, acc};
  assign wide      = (acc_w << 3) + (acc_w << 1) + {{OUT_W{1'b0}}, digit};
  assign result    = wide[OUT_W-1:0];
  assign unused_hi = ^wide[OUT_W+3:OUT_W];

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: folds NDIG digits MSD-first, one per clock,
// with a start/busy/done handshake and an error flag for non-decimal digits.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIG  = 2,
  parameter int OUT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [OUT_W-1:0]  bin_out
);

  localparam int CW = $clog2(NDIG + 1);

  if (NDIG < 1 || NDIG > 4) begin : g_ndig_check
    $error("bcd_to_bin_seq: NDIG must be in 1..4");
  end
  if (OUT_W < min_bin_width(NDIG)) begin : g_width_check
    $error("bcd_to_bin_seq: OUT_W too narrow for NDIG digits");
  end

  // Handshake: start is taken on a rising edge only in IDLE or DONE; busy is high
  // while digits are folded; done pulses one cycle when bin_out/err are updated.
  state_t            state, state_nxt;
  logic [4*NDIG-1:0] sreg;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  mac_out;
  logic [CW-1:0]     cnt;
  logic              bad;
  logic              bad_nxt;
  logic [3:0]        nibble;
  logic              last;
  logic              accept;

  assign nibble  = sreg[4*NDIG-1 -: 4];
  assign last    = (cnt == CW'(NDIG - 1));
  assign bad_nxt = bad | ~bcd_digit_valid(nibble);
  assign accept  = start && (state != CONV);

  bcd_mac10 #(.OUT_W(OUT_W)) u_mac10 (
    .acc    (acc),
    .digit  (nibble),
    .result (mac_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? CONV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CONV:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      bad     <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else if (accept) begin
      sreg <= bcd_in;
      acc  <= '0;
      cnt  <= '0;
      bad  <= 1'b0;
    end else if (state == CONV) begin
      acc  <= mac_out;
      bad  <= bad_nxt;
      sreg <= sreg << 4;
      cnt  <= cnt + 1'b1;
      if (last) begin
        bin_out <= bad_nxt ? '0 : mac_out;
        err     <= bad_nxt;
      end
    end
  end

endmodule
